// File: rtl/dspl_drv_param.sv
// Time-multiplexed N-digit 7-segment driver with frame-latched digit data,
// per-digit blink, PWM brightness and a frame-boundary tick. Outputs are active-low.
module dspl_drv_param #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_LOG2 = 17,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              dec_ddp,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [REFRESH_LOG2-1:0] r_refresh_cnt;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [FRM_W-1:0]        r_frame_cnt;
  logic                    r_blink_phase;
  logic [7*NUM_DIGITS-1:0] r_digits_sh;
  logic [NUM_DIGITS-1:0]   r_mask_sh;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_dec;
  logic                    r_tick;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic [6:0]              w_cur;
  logic                    w_cur_mask;
  logic [BRIGHT_W-1:0]     w_top;
  logic                    w_drive;
  logic [6:0]              w_seg;
  logic [7:0]              w_dec_next;
  logic [NUM_DIGITS-1:0]   w_an_next;

  assign w_slot_end  = &r_refresh_cnt;
  assign w_frame_end = w_slot_end && (r_digit_idx == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    w_cur      = '0;
    w_cur_mask = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i)) begin
        w_cur      = r_digits_sh[7*i +: 7];
        w_cur_mask = r_mask_sh[i];
      end
    end
  end

  // PWM: the top bits of the slot counter form a ramp compared to live brightness
  assign w_top   = r_refresh_cnt[REFRESH_LOG2-1 -: BRIGHT_W];
  assign w_drive = w_cur[6] && (w_top <= brightness) && !(r_blink_phase && w_cur_mask);

  always_comb begin
    w_seg = 7'h7F;
    case (w_cur[5:1])
      5'h00: w_seg = 7'h40;
      5'h01: w_seg = 7'h79;
      5'h02: w_seg = 7'h24;
      5'h03: w_seg = 7'h30;
      5'h04: w_seg = 7'h19;
      5'h05: w_seg = 7'h12;
      5'h06: w_seg = 7'h02;
      5'h07: w_seg = 7'h78;
      5'h08: w_seg = 7'h00;
      5'h09: w_seg = 7'h10;
      5'h0A: w_seg = 7'h08;
      5'h0B: w_seg = 7'h03;
      5'h0C: w_seg = 7'h46;
      5'h0D: w_seg = 7'h21;
      5'h0E: w_seg = 7'h06;
      5'h0F: w_seg = 7'h0E;
      5'h11: w_seg = 7'h3F;
      5'h12: w_seg = 7'h47;
      5'h13: w_seg = 7'h0C;
      5'h14: w_seg = 7'h41;
      default: w_seg = 7'h7F;
    endcase
  end

  assign w_dec_next = w_drive ? {~w_cur[0], w_seg} : 8'hFF;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign w_an_next[gi] = !(w_drive && (r_digit_idx == IDX_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_digits_sh   <= digits;
      r_mask_sh     <= blink_mask;
      r_an          <= '1;
      r_dec         <= 8'hFF;
      r_tick        <= 1'b0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + REFRESH_LOG2'(1);
      r_an          <= w_an_next;
      r_dec         <= w_dec_next;
      r_tick        <= w_frame_end;
      if (w_slot_end) begin
        if (r_digit_idx == IDX_W'(NUM_DIGITS - 1))
          r_digit_idx <= '0;
        else
          r_digit_idx <= r_digit_idx + IDX_W'(1);
      end
      // New data and new blink phase land together so a frame never mixes old and new
      if (w_frame_end) begin
        r_digits_sh <= digits;
        r_mask_sh   <= blink_mask;
        if (r_frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FRM_W'(1);
        end
      end
    end
  end

  assign an         = r_an;
  assign dec_ddp    = r_dec;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_dspl_drv_param.sv
// Scoreboard bench for dspl_drv_param (4 digits, 16-clock slots, 2-bit brightness,
// 2-frame blink): expected outputs are queued per edge and compared one cycle later.
module tb_dspl_drv_param;

  localparam int N   = 4;
  localparam int RL  = 4;
  localparam int BW  = 2;
  localparam int BF  = 2;
  localparam int SLOT  = 1 << RL;
  localparam int FRAME = N * SLOT;

  logic           clock;
  logic           reset;
  logic [7*N-1:0] digits;
  logic [N-1:0]   blink_mask;
  logic [BW-1:0]  brightness;
  logic [N-1:0]   an;
  logic [7:0]     dec_ddp;
  logic           frame_tick;

  dspl_drv_param #(
    .NUM_DIGITS(N), .REFRESH_LOG2(RL), .BRIGHT_W(BW), .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock), .reset(reset), .digits(digits), .blink_mask(blink_mask),
    .brightness(brightness), .an(an), .dec_ddp(dec_ddp), .frame_tick(frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [N-1:0] an;
    logic [7:0]   dec;
    logic         tick;
  } exp_t;

  exp_t     sb[$];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       s = 0;
  logic [7*N-1:0] m_dig;
  logic [N-1:0]   m_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_tbl(input logic [4:0] code);
    case (code)
      5'h00: return 8'hC0;  5'h01: return 8'hF9;  5'h02: return 8'hA4;  5'h03: return 8'hB0;
      5'h04: return 8'h99;  5'h05: return 8'h92;  5'h06: return 8'h82;  5'h07: return 8'hF8;
      5'h08: return 8'h80;  5'h09: return 8'h90;  5'h0A: return 8'h88;  5'h0B: return 8'h83;
      5'h0C: return 8'hC6;  5'h0D: return 8'hA1;  5'h0E: return 8'h86;  5'h0F: return 8'h8E;
      5'h11: return 8'hBF;  5'h12: return 8'hC7;  5'h13: return 8'h8C;  5'h14: return 8'hC1;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic exp_t model();
    exp_t e;
    int cnt, idx, frame, phase;
    logic [6:0] d;
    logic drive;
    e.an = '1; e.dec = 8'hFF; e.tick = 1'b0;
    if (reset) return e;
    cnt   = s % SLOT;
    idx   = (s / SLOT) % N;
    frame = s / FRAME;
    phase = (frame / BF) % 2;
    d     = m_dig[7*idx +: 7];
    drive = d[6] && ((cnt >> (RL - BW)) <= int'(brightness)) && !(phase == 1 && m_mask[idx]);
    if (drive) begin
      e.an  = ~(N'(1) << idx);
      e.dec = seg_tbl(d[5:1]) & ~{d[0], 7'h00};
    end
    e.tick = ((s % FRAME) == FRAME - 1);
    return e;
  endfunction

  task automatic cyc();
    exp_t e;
    e = model();
    sb.push_back(e);
    @(posedge clock);
    #1;
    check("sb_depth", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("an", an, e.an);
      check("dec_ddp", dec_ddp, e.dec);
      check("frame_tick", frame_tick, e.tick);
    end
    if (reset) begin
      s = 0; m_dig = digits; m_mask = blink_mask;
    end else begin
      if ((s % FRAME) == FRAME - 1) begin
        m_dig = digits; m_mask = blink_mask;
      end
      s++;
    end
  endtask

  function automatic logic [6:0] dg(input logic en, input logic [4:0] code, input logic dp);
    return {en, code, dp};
  endfunction

  initial begin
    reset      = 1'b1;
    digits     = 28'($urandom);
    blink_mask = N'($urandom);
    brightness = BW'($urandom);
    m_dig = '0; m_mask = '0;

    // reset held with arbitrary inputs
    repeat (3) cyc();

    // full scan plus mid-frame update of digit 0
    digits     = {dg(1, 5'h04, 0), dg(1, 5'h03, 0), dg(1, 5'h02, 0), dg(1, 5'h01, 0)};
    blink_mask = '0;
    brightness = 2'd3;
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      if (k == 20) digits[6:0] = dg(1, 5'h11, 0);
      cyc();
      if (k == 1)  begin check("scan_c1_an", an, 4'hE); check("scan_c1_dec", dec_ddp, 8'hF9); end
      if (k == 17) check("scan_c17_dec", dec_ddp, 8'hA4);
      if (k == 64) check("scan_tick64", frame_tick, 1'b1);
      if (k == 64) check("tear_c64_dec", dec_ddp, 8'h99);
      if (k == 65) check("tear_c65_dec", dec_ddp, 8'hBF);
    end

    // brightness 1 then 0, each from a fresh reset
    reset = 1'b1; brightness = 2'd1;
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      cyc();
      if (k == 8) check("bri1_c8_an", an, 4'hE);
      if (k == 9) check("bri1_c9_an", an, 4'hF);
    end
    reset = 1'b1; brightness = 2'd0;
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      cyc();
      if (k == 4) check("bri0_c4_an", an, 4'hE);
      if (k == 5) check("bri0_c5_an", an, 4'hF);
    end

    // blink on digit 1 across five frames
    reset = 1'b1; brightness = 2'd3; blink_mask = 4'b0010;
    digits = {dg(1, 5'h12, 0), dg(1, 5'h13, 1), dg(1, 5'h14, 0), dg(1, 5'h0A, 0)};
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= 5 * FRAME; k++) begin
      cyc();
      if (k == 20)  check("blink_f0_an", an, 4'hD);
      if (k == 150) begin check("blink_f2_an", an, 4'hF); check("blink_f2_dec", dec_ddp, 8'hFF); end
      if (k == 170) check("blink_f2_d2", dec_ddp, 8'h0C);
    end

    // digit 2 disabled, dp on digit 3, reset asserted mid-frame
    reset = 1'b1; blink_mask = '0;
    digits = {dg(1, 5'h0F, 1), dg(0, 5'h08, 0), dg(1, 5'h0B, 0), dg(1, 5'h00, 0)};
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= 39; k++) begin
      cyc();
      if (k == 36) check("dis_an2", an, 4'hF);
    end
    reset = 1'b1;
    cyc();
    check("midrst_an", an, 4'hF);
    reset = 1'b0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      cyc();
      if (k == 1)  check("rst_restart_an", an, 4'hE);
      if (k == 60) check("dp_d3_dec", dec_ddp, 8'h0E);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
